// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises the raw pins, deframes 11-bit
// frames into scan codes and queues them in a small FIFO for the display logic.
module ps2_scancode_rx #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [2:0]         ps2c_sync_q;
    logic [1:0]         ps2d_sync_q;
    logic [3:0]         cnt_q, cnt_d;
    logic [9:0]         shift_q, shift_d;
    logic [15:0]        tout_q, tout_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [DEPTH];
    logic               ready_q;
    logic               overflow_q, overflow_d;
    logic               frame_err_q, frame_err_d;

    logic               fall;
    logic               sample;
    logic               full;
    logic               write_en;

    assign fall   = ps2c_sync_q[2] & ~ps2c_sync_q[1];
    assign sample = ps2d_sync_q[1];
    assign full   = (wr_ptr_q + 1'b1) == rd_ptr_q;

    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tout_d      = tout_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        frame_err_d = 1'b0;
        write_en    = 1'b0;

        if (fall) begin
            tout_d = '0;
            if (cnt_q == 4'd10) begin
                // shift_q holds start in bit 0, d0..d7 in [8:1], parity in bit 9
                cnt_d = '0;
                if (!shift_q[0] && sample && (^shift_q[9:1])) begin
                    if (!full) begin
                        write_en = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d = {sample, shift_q[9:1]};
                cnt_d   = cnt_q + 4'd1;
            end
        end else if (cnt_q != 4'd0) begin
            if (tout_q == 16'(TIMEOUT_CYCLES - 1)) begin
                cnt_d       = '0;
                tout_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                tout_d = tout_q + 16'd1;
            end
        end else begin
            tout_d = '0;
        end

        if (!nextdata_n && ready_q) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2c_sync_q <= 3'b111;
            ps2d_sync_q <= 2'b11;
            cnt_q       <= '0;
            shift_q     <= '0;
            tout_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[1:0], ps2_clk};
            ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tout_q      <= tout_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= (wr_ptr_d != rd_ptr_d);
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            if (write_en) begin
                mem_q[wr_ptr_q] <= shift_q[8:1];
            end
        end
    end

    assign data      = mem_q[rd_ptr_q];
    assign ready     = ready_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: a vector table of single frames plus
// hand-written sequences for latency, ordering, overflow, timeout and reset.
module tb_ps2_scancode_rx;

    localparam int TOUT = 64;
    localparam int HALF = 8;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int compared   = 0;
    int mismatched = 0;
    int errCycles  = 0;

    ps2_scancode_rx #(.FIFO_AW(3), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every clock during which frame_err is high, so a single-cycle
    // pulse adds exactly one.
    always @(posedge clk) begin
        if (clrn && frame_err) errCycles <= errCycles + 1;
    end

    typedef struct {
        logic [7:0] payload;
        logic       flipParity;
        logic       badStart;
        logic       badStop;
        logic       expReady;
        int         expErr;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [10:0] makeFrame(input logic [7:0] payload, input logic flipParity,
                                              input logic badStart, input logic badStop);
        logic parity;
        parity = (~^payload) ^ flipParity;
        return {~badStop, parity, payload, badStart};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the first nbits bits of a frame LSB first, ending with ps2_clk high.
    task automatic applyStimulus(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic applyPop();
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        int errBefore;
        logic [10:0] fr;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[5] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[7] = '{8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[8] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 0};

        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        repeat (4) @(negedge clk);

        // Ignored pop while empty must not disturb the pointers.
        applyPop();
        checkOutput("empty_pop_ready", 32'(ready), 32'd0);

        for (int v = 0; v < 9; v++) begin
            errBefore = errCycles;
            applyStimulus(makeFrame(vecs[v].payload, vecs[v].flipParity,
                                    vecs[v].badStart, vecs[v].badStop), 11);
            checkOutput($sformatf("vec%0d_ready", v), 32'(ready), 32'(vecs[v].expReady));
            if (vecs[v].expReady) begin
                checkOutput($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].payload));
            end
            checkOutput($sformatf("vec%0d_err", v), 32'(errCycles - errBefore), 32'(vecs[v].expErr));
            if (ready) begin
                applyPop();
                @(negedge clk);
                checkOutput($sformatf("vec%0d_popped", v), 32'(ready), 32'd0);
            end
        end
        checkOutput("table_overflow", 32'(overflow), 32'd0);

        // Ready must rise on the third clk after the stop-bit pin fall.
        fr = makeFrame(8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(fr, 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("latency_early_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_ready", 32'(ready), 32'd1);
        checkOutput("latency_data", 32'(data), 32'h1C);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        applyPop();
        @(negedge clk);
        checkOutput("latency_popped", 32'(ready), 32'd0);

        applyStimulus(makeFrame(8'hF0, 1'b0, 1'b0, 1'b0), 11);
        applyStimulus(makeFrame(8'h1C, 1'b0, 1'b0, 1'b0), 11);
        checkOutput("b2b_first", 32'(data), 32'hF0);
        applyPop();
        @(negedge clk);
        checkOutput("b2b_mid_ready", 32'(ready), 32'd1);
        checkOutput("b2b_second", 32'(data), 32'h1C);
        applyPop();
        @(negedge clk);
        checkOutput("b2b_empty", 32'(ready), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(makeFrame(8'(i), 1'b0, 1'b0, 1'b0), 11);
            if (i == 7) checkOutput("ovf_before", 32'(overflow), 32'd0);
        end
        checkOutput("ovf_after", 32'(overflow), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            checkOutput($sformatf("ovf_ready%0d", i), 32'(ready), 32'd1);
            checkOutput($sformatf("ovf_data%0d", i), 32'(data), 32'(i));
            applyPop();
        end
        @(negedge clk);
        checkOutput("ovf_drained", 32'(ready), 32'd0);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);

        errBefore = errCycles;
        applyStimulus(makeFrame(8'h1C, 1'b0, 1'b0, 1'b0), 5);
        repeat (TOUT + 5) @(negedge clk);
        checkOutput("timeout_err", 32'(errCycles - errBefore), 32'd1);
        checkOutput("timeout_ready", 32'(ready), 32'd0);
        applyStimulus(makeFrame(8'h1C, 1'b0, 1'b0, 1'b0), 11);
        checkOutput("timeout_recover_ready", 32'(ready), 32'd1);
        checkOutput("timeout_recover_data", 32'(data), 32'h1C);
        applyPop();

        applyStimulus(makeFrame(8'h11, 1'b0, 1'b0, 1'b0), 11);
        applyStimulus(makeFrame(8'h22, 1'b0, 1'b0, 1'b0), 11);
        applyStimulus(makeFrame(8'h33, 1'b0, 1'b0, 1'b0), 11);
        applyStimulus(makeFrame(8'h44, 1'b0, 1'b0, 1'b0), 4);
        checkOutput("prerst_data", 32'(data), 32'h11);
        #3;
        clrn = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(ready), 32'd0);
        checkOutput("midrst_data", 32'(data), 32'h00);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        errBefore = errCycles;
        applyStimulus(makeFrame(8'h1C, 1'b0, 1'b0, 1'b0), 11);
        checkOutput("postrst_ready", 32'(ready), 32'd1);
        checkOutput("postrst_data", 32'(data), 32'h1C);
        checkOutput("postrst_err", 32'(errCycles - errBefore), 32'd0);
        applyPop();
        @(negedge clk);
        checkOutput("postrst_empty", 32'(ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
